// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and the squash word.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  // Word written into IF/ID when a wrong-path instruction is squashed.
  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and the memory (slave).
interface fetch_stage_if #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 32
);

  logic [PC_W-1:0]    pc;
  logic               mem_read;
  logic [INSTR_W-1:0] instr_in;

  modport master (output pc, output mem_read, input instr_in);
  modport slave  (input pc, input mem_read, output instr_in);

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats load, neither means hold.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_plus1_in,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc_plus1,
  output logic               valid
);

  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [PC_W-1:0]    pc_plus1_d, pc_plus1_q;
  logic               valid_d, valid_q;

  // Next-state selection; a flush keeps the stale pc_plus1 since the entry is invalid anyway.
  always_comb begin
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d = INSTR_W'(NOP_INSTR);
      valid_d = 1'b0;
    end else if (load) begin
      instr_d    = instr_in;
      pc_plus1_d = pc_plus1_in;
      valid_d    = 1'b1;
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc_plus1 = pc_plus1_q;
  assign valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM and IF/ID capture.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/squash counters.
module fetch_stage #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               halt_req,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc_plus1,
  output logic               ifid_valid,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   perf_fetched,
  output logic [CNT_W-1:0]   perf_squashed
`endif
);

  import fetch_pkg::*;

  fetch_state_e      state_d, state_q;
  logic [PC_W-1:0]   pc_d, pc_q, pc_inc;
  logic              mem_read_d, mem_read_q;
  logic              halted_d, halted_q;
  logic              load, flush;

  assign pc_inc = PC_W'(pc_q + 1'b1);

  // Fetch control: redirects beat stall; halt_req still lets this edge's action complete.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (branch_taken) begin
          pc_d  = branch_target;
          flush = 1'b1;
        end else if (jump) begin
          pc_d  = jump_target;
          flush = 1'b1;
        end else if (!stall) begin
          pc_d  = pc_inc;
          load  = 1'b1;
        end
        if (halt_req) state_d = S_HALT;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    mem_read_d = (state_d == S_RUN);
    halted_d   = (state_d == S_HALT);
  end

  // FSM, PC and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      mem_read_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_read_q <= mem_read_d;
      halted_q   <= halted_d;
    end
  end

  ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ifid_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .flush       (flush),
    .instr_in    (imem.instr_in),
    .pc_plus1_in (pc_inc),
    .instr       (ifid_instr),
    .pc_plus1    (ifid_pc_plus1),
    .valid       (ifid_valid)
  );

  assign imem.pc       = pc_q;
  assign imem.mem_read = mem_read_q;
  assign halted        = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetched_d, fetched_q;
  logic [CNT_W-1:0] squashed_d, squashed_q;

  // Saturating counters; a squash only counts when it discards a valid entry.
  always_comb begin
    fetched_d  = fetched_q;
    squashed_d = squashed_q;
    if (load && (fetched_q != '1)) fetched_d = fetched_q + 1'b1;
    if (flush && ifid_valid && (squashed_q != '1)) squashed_d = squashed_q + 1'b1;
  end

  // Counter storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q  <= '0;
      squashed_q <= '0;
    end else begin
      fetched_q  <= fetched_d;
      squashed_q <= squashed_d;
    end
  end

  assign perf_fetched  = fetched_q;
  assign perf_squashed = squashed_q;
`else
  logic unused_cnt_cfg;
  assign unused_cnt_cfg = (CNT_W > 0);
`endif

endmodule
